srl_shift_checker: RTL
======================

// Module: srl_shift_checker
// PURPOSE
// - Stimulus generator and self-checker for a bank of NCHAIN SRL32 shift chains instantiated beside it in the test top.
// - Drives shared serial data and clock-enable into the chains, keeps a 32-bit reference history and compares every
//   chain's tapped output and cascade output against it each cycle.
// - Sticky per-chain error flags leave on error[7:0], which the top routes to led[7:0]; any set bit fails the testbench.
// PARAMETERS
// - NCHAIN       8             number of SRL32 chains under test (1..8)
// - TAPS         {5'd31,..,0}  NCHAIN*5 packed tap addresses; chain i uses TAPS[5*i+:5]
// - LFSR_SEED    32'hACE1_1234 nonzero reset value of the data LFSR
// - CE_DITHER    1             1: CE gated by an LFSR bit (about 50% duty); 0: CE = en
// PORTS
// - clk        in   1          fabric clock, all state on rising edge
// - rst_n      in   1          asynchronous active-low reset
// - en         in   1          run enable (top ties it to ~sw[0]); low freezes shifting
// - srl_d      out  1          serial data to every chain D
// - srl_ce     out  1          clock enable to every chain CE
// - srl_a      out  NCHAIN*5   per-chain address, constant = TAPS
// - srl_q      in   NCHAIN     per-chain Q (tapped output)
// - srl_q31    in   NCHAIN     per-chain Q31 (cascade output)
// - error      out  8          sticky per-chain mismatch flags; bits >= NCHAIN tied 0
// - checking   out  1          1 once the history is primed and compares are live
// BEHAVIOUR
// - Reset (async assert, sync release): lfsr=LFSR_SEED, hist=0, fill=0, srl_d=0, srl_ce=0, error=0, checking=0, state=FILL.
// - LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1; advances every cycle en=1, regardless of CE.
// - srl_d = lfsr[0] and srl_ce = en & (CE_DITHER ? lfsr[16] : 1), both registered outputs (no comb paths to ports).
// - hist shifts on exactly the edges where registered srl_ce=1: hist <= {hist[30:0], srl_d}; matches chain contents.
// - Expected: exp_q[i] = hist[TAPS_i] (bit 0 = most recent shift), exp_q31[i] = hist[31].
// - States: FILL -> CHECK when fill reaches 32 (fill counts CE edges, 6-bit, saturates at 32); CHECK is terminal
//   until reset. checking = (state==CHECK), registered.
// - Compare in CHECK every cycle (including en=0, when chain outputs are static): mm[i] = (srl_q[i]^exp_q[i]) |
//   (srl_q31[i]^exp_q31[i]); registered one stage, then error[i] <= error[i] | mm_r[i]. Latency mismatch->flag: 2 clks.
// - Comparison uses hist/srl_q sampled on the same edge; because hist and the chains update on the same CE edge,
//   no extra alignment is needed.
// - en deasserted mid-run: LFSR, hist, fill freeze; state and error keep value; resumes seamlessly on en=1.
// - en=0 in FILL: stays in FILL, no compares, error stays 0.
// - Reset mid-CHECK: all flags clear immediately (async), FILL restarts; chains keep stale data, which is harmless
//   because 32 fresh shifts precede the next compare.
// - Flags never self-clear; only rst_n clears them.
// - Unknown X on srl_q counts as mismatch in simulation (use !== semantics only in assertions, RTL uses ^).
// STRUCTURE
// - Shared package srl_test_pkg: LFSR_POLY constant, SRL_DEPTH=32, fill_w/state enum (FILL, CHECK).
// - One sub-module: srl_ref_lfsr (seeded Galois LFSR with enable), reused by other SRL16/SRL32 tests.
// - Rest (CE gen, history, fill counter, FSM, compare pipe, sticky flags) flat in this module.
// TESTING
// - Reset then en=1, ideal SRL32 models with TAPS 0..7 -> checking rises after 32 CE edges, error stays 8'h00 for 5000 clks.
// - Force srl_q[3] inverted for one cycle in CHECK -> error == 8'h08 two clks later and stays set.
// - Swap chain 5 for a model with tap off by one (A+1) -> error[5] set within 40 CE edges of checking; others 0.
// - Drop en for 100 clks mid-CHECK -> srl_ce=0, hist/lfsr unchanged, no new errors; resume passes.
// - Corrupt srl_q31[0] during FILL -> error stays 0 (no compare before checking=1).
// - Pulse rst_n low 3 ns mid-CHECK with error=8'h08 -> error 0, checking 0 immediately; re-primes and passes.

Source files
------------

// File: rtl/srl_test_pkg.sv
// Shared definitions for the SRL16/SRL32 shift-chain test logic: chain depth,
// fill-counter type, checker states and the reference LFSR polynomial.
package srl_test_pkg;

  localparam int SRL_DEPTH = 32;
  localparam int FILL_W    = 6;

  // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1.
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  typedef logic [FILL_W-1:0] fill_t;

  typedef enum logic {
    FILL  = 1'b0,
    CHECK = 1'b1
  } state_t;

  // One step of a right-shifting Galois LFSR.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] poly);
    return (s >> 1) ^ (s[0] ? poly : 32'h0);
  endfunction

endpackage

// File: rtl/srl_ref_lfsr.sv
// Seeded 32-bit Galois LFSR with a step enable; the state register is the output.
module srl_ref_lfsr
  import srl_test_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_1234,
  parameter logic [31:0] POLY = LFSR_POLY
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [31:0] state_o
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;

  assign lfsr_d  = lfsr_step(lfsr_q, POLY);
  assign state_o = lfsr_q;

  // Advance one step per enabled cycle; hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (en_i) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values, avoiding simulation races.
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/srl_shift_checker.sv
// Stimulus generator and self-checker for a bank of SRL32 shift chains.
// Drives shared serial data/CE, tracks a 32-bit reference history of what was
// shifted in, and flags (stickily) any chain whose Q or Q31 disagrees with it.
module srl_shift_checker
  import srl_test_pkg::*;
#(
  parameter int               NCHAIN    = 8,
  parameter logic [NCHAIN*5-1:0] TAPS   = {5'd31, 5'd23, 5'd15, 5'd7, 5'd3, 5'd2, 5'd1, 5'd0},
  parameter logic [31:0]      LFSR_SEED = 32'hACE1_1234,
  parameter bit               CE_DITHER = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  output logic                srl_d,
  output logic                srl_ce,
  output logic [NCHAIN*5-1:0] srl_a,
  input  logic [NCHAIN-1:0]   srl_q,
  input  logic [NCHAIN-1:0]   srl_q31,
  output logic [7:0]          error,
  output logic                checking
);

  localparam fill_t FILL_DONE = fill_t'(SRL_DEPTH);

  logic [31:0]           lfsr;
  logic                  srl_d_q;
  logic                  srl_ce_q;
  logic                  srl_ce_d;
  logic [SRL_DEPTH-1:0]  hist_q;
  fill_t                 fill_q;
  state_t                state_q;
  logic                  checking_q;
  logic [NCHAIN-1:0]     mm_d;
  logic [NCHAIN-1:0]     mm_q;
  logic [NCHAIN-1:0]     error_q;
  logic                  unused_lfsr_bits;

  srl_ref_lfsr #(
    .SEED (LFSR_SEED),
    .POLY (LFSR_POLY)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (en),
    .state_o (lfsr)
  );

  // Only bit 0 (data) and bit 16 (CE dither) leave the LFSR.
  assign unused_lfsr_bits = ^{lfsr[31:17], lfsr[15:1]};

  assign srl_ce_d = en & (CE_DITHER ? lfsr[16] : 1'b1);

  // Registered chain drive so no combinational path reaches the ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srl_d_q  <= 1'b0;
      srl_ce_q <= 1'b0;
    end else begin
      srl_d_q  <= lfsr[0];
      srl_ce_q <= srl_ce_d;
    end
  end

  // Reference history and fill count follow exactly the CE edges the chains see.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (srl_ce_q) begin
      hist_q <= {hist_q[SRL_DEPTH-2:0], srl_d_q};
      if (fill_q != FILL_DONE) begin
        fill_q <= fill_q + fill_t'(1);
      end
    end
  end

  // FILL until 32 fresh shifts are in the chains, then CHECK until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      checking_q <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (fill_q == FILL_DONE) begin
            state_q    <= CHECK;
            checking_q <= 1'b1;
          end
        end
        CHECK: begin
          state_q    <= CHECK;
          checking_q <= 1'b1;
        end
        default: begin
          state_q    <= FILL;
          checking_q <= 1'b0;
        end
      endcase
    end
  end

  // Per-chain mismatch against the history; X on a chain output propagates as a mismatch.
  always_comb begin
    // NOTE: default every comb output first so no path leaves it unassigned (no latch).
    mm_d = '0;
    if (state_q == CHECK) begin
      for (int i = 0; i < NCHAIN; i++) begin
        mm_d[i] = (srl_q[i]   ^ hist_q[TAPS[5*i +: 5]]) |
                  (srl_q31[i] ^ hist_q[SRL_DEPTH-1]);
      end
    end
  end

  // One pipeline stage on the compare, then sticky accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mm_q    <= '0;
      error_q <= '0;
    end else begin
      mm_q    <= mm_d;
      error_q <= error_q | mm_q;
    end
  end

  // Zero-extend the flags onto the fixed 8-bit LED bus.
  always_comb begin
    error              = '0;
    error[NCHAIN-1:0]  = error_q;
  end

  assign srl_d    = srl_d_q;
  assign srl_ce   = srl_ce_q;
  assign srl_a    = TAPS;
  assign checking = checking_q;

endmodule
